// File: rtl/interrupt_controller_pkg.sv
// Shared INTCON bit positions, handshake FSM encodings, source numbering and the core-source helper.
// Used by the interrupt controller top and its source encoder.
package interrupt_controller_pkg;

  localparam int GIE_BIT  = 7;
  localparam int PEIE_BIT = 6;
  localparam int T0IE_BIT = 5;
  localparam int INTE_BIT = 4;
  localparam int RBIE_BIT = 3;
  localparam int T0IF_BIT = 2;
  localparam int INTF_BIT = 1;
  localparam int RBIF_BIT = 0;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TAKE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_IN_ISR   = 2'd3;

  localparam logic [12:0] IRQ_VECTOR = 13'h004;

  // Enabled core sources packed in source-index order: [0]=INTF, [1]=T0IF, [2]=RBIF.
  function automatic logic [2:0] core_sources(input logic [7:0] intcon);
    return {intcon[RBIE_BIT] & intcon[RBIF_BIT],
            intcon[T0IE_BIT] & intcon[T0IF_BIT],
            intcon[INTE_BIT] & intcon[INTF_BIT]};
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// SFR-side and core-side signals of the interrupt controller; master = SFR file / core, slave = controller.
// All signals share the controller's clock; no flow control beyond the single-cycle strobes.
interface interrupt_controller_if #(
  parameter int NUM_PIR = 2
);
  logic                   intcon_wr_en;
  logic [7:0]             intcon_d;
  logic [7:0]             intcon_q;
  logic                   t0if_strobe;
  logic                   intf_strobe;
  logic                   rbif_strobe;
  logic [8*NUM_PIR-1:0]   pir_q;
  logic [8*NUM_PIR-1:0]   pie_q;
  logic                   instr_boundary;
  logic                   vector_ack;
  logic                   retfie;
  logic                   irq_take;
  logic                   in_isr;
  logic                   wake;
  logic [4:0]             irq_source;

  modport master (
    output intcon_wr_en, intcon_d, t0if_strobe, intf_strobe, rbif_strobe,
    output pir_q, pie_q, instr_boundary, vector_ack, retfie,
    input  intcon_q, irq_take, in_isr, wake, irq_source
  );

  modport slave (
    input  intcon_wr_en, intcon_d, t0if_strobe, intf_strobe, rbif_strobe,
    input  pir_q, pie_q, instr_boundary, vector_ack, retfie,
    output intcon_q, irq_take, in_isr, wake, irq_source
  );
endinterface

// File: rtl/intc_priority_encoder.sv
// Lowest-index-wins encoder over the enabled pending interrupt sources.
// Purely combinational; vld low when no request is set (idx then 0).
module intc_priority_encoder #(
  parameter int N = 19
) (
  input  logic [N-1:0] req,
  output logic [4:0]   idx,
  output logic         vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 5'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// INTCON owner and interrupt-acceptance handshake into the core; irq_take follows the acceptance edge by one cycle.
// Optional INTC_SOURCE_ID_EN latches the accepted source index on irq_source; otherwise irq_source is 0.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int         NUM_PIR      = 2,
  parameter logic [7:0] INTCON_RESET = 8'h00
) (
  input logic                   clk,
  input logic                   rst,
  interrupt_controller_if.slave bus
);

  logic [7:0] intcon_q, intcon_d;
  logic [1:0] state_q, state_d;
  logic       irq_take_q, irq_take_d;
  logic       in_isr_q, in_isr_d;

  logic periph_pend;
  logic core_pend;
  logic pending;
  logic accept;

  always_comb begin
    periph_pend = |(bus.pir_q & bus.pie_q);
    core_pend   = |core_sources(intcon_q);
    pending     = core_pend | (intcon_q[PEIE_BIT] & periph_pend);
    accept      = (state_q == ST_IDLE) & intcon_q[GIE_BIT] & pending & bus.instr_boundary;
  end

  // Priority low to high: CPU write, hardware flag set, RETFIE, acceptance.
  always_comb begin
    intcon_d = bus.intcon_wr_en ? bus.intcon_d : intcon_q;
    if (bus.t0if_strobe) intcon_d[T0IF_BIT] = 1'b1;
    if (bus.intf_strobe) intcon_d[INTF_BIT] = 1'b1;
    if (bus.rbif_strobe) intcon_d[RBIF_BIT] = 1'b1;
    if (bus.retfie)      intcon_d[GIE_BIT]  = 1'b1;
    if (accept)          intcon_d[GIE_BIT]  = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept)         state_d = ST_TAKE;
      ST_TAKE:                         state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (bus.vector_ack) state_d = ST_IN_ISR;
      ST_IN_ISR:   if (bus.retfie)     state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    irq_take_d = (state_d == ST_TAKE);
    in_isr_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      intcon_q   <= INTCON_RESET;
      state_q    <= ST_IDLE;
      irq_take_q <= 1'b0;
      in_isr_q   <= 1'b0;
    end else begin
      intcon_q   <= intcon_d;
      state_q    <= state_d;
      irq_take_q <= irq_take_d;
      in_isr_q   <= in_isr_d;
    end
  end

  assign bus.intcon_q = intcon_q;
  assign bus.irq_take = irq_take_q;
  assign bus.in_isr   = in_isr_q;
  assign bus.wake     = pending;

`ifdef INTC_SOURCE_ID_EN
  localparam int NSRC = 8 * NUM_PIR + 3;

  logic [NSRC-1:0] src_req;
  logic [4:0]      src_idx;
  logic            src_vld;
  logic [4:0]      irq_source_q, irq_source_d;

  // Peripheral bits only count as enabled when PEIE is set, matching the acceptance rule.
  always_comb begin
    src_req      = {bus.pir_q & bus.pie_q & {(8 * NUM_PIR){intcon_q[PEIE_BIT]}},
                    core_sources(intcon_q)};
    irq_source_d = (accept && src_vld) ? src_idx : irq_source_q;
  end

  intc_priority_encoder #(.N(NSRC)) u_prio (
    .req (src_req),
    .idx (src_idx),
    .vld (src_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) irq_source_q <= 5'd0;
    else     irq_source_q <= irq_source_d;
  end

  assign bus.irq_source = irq_source_q;
`else
  assign bus.irq_source = 5'd0;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model of the interrupt controller.
module tb_interrupt_controller;

`ifdef INTC_SOURCE_ID_EN
  localparam bit SRC_ON = 1'b1;
`else
  localparam bit SRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_PIR(2)) bus ();

  interrupt_controller #(.NUM_PIR(2), .INTCON_RESET(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model helpers ----------------
  function automatic bit model_src_bit(input bit [7:0] ic, input bit [15:0] pir, input bit [15:0] pie, input int n);
    if (n == 0) return ic[4] & ic[1];
    if (n == 1) return ic[5] & ic[2];
    if (n == 2) return ic[3] & ic[0];
    return ic[6] & pir[n-3] & pie[n-3];
  endfunction

  function automatic bit model_pend(input bit [7:0] ic, input bit [15:0] pir, input bit [15:0] pie);
    for (int n = 0; n < 19; n++) if (model_src_bit(ic, pir, pie, n)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [4:0] model_lowest(input bit [7:0] ic, input bit [15:0] pir, input bit [15:0] pie);
    for (int n = 0; n < 19; n++) if (model_src_bit(ic, pir, pie, n)) return 5'(n);
    return 5'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.intcon_wr_en = 1'b0; bus.intcon_d = 8'h00;
    bus.t0if_strobe = 1'b0; bus.intf_strobe = 1'b0; bus.rbif_strobe = 1'b0;
    bus.pir_q = 16'h0000; bus.pie_q = 16'h0000;
    bus.instr_boundary = 1'b0; bus.vector_ack = 1'b0; bus.retfie = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_intcon(input logic [7:0] v);
    bus.intcon_wr_en = 1'b1; bus.intcon_d = v;
    tick();
    bus.intcon_wr_en = 1'b0;
  endtask

  task automatic finish_isr;
    bus.instr_boundary = 1'b0;
    tick();
    bus.vector_ack = 1'b1;
    tick();
    bus.vector_ack = 1'b0; bus.retfie = 1'b1;
    tick();
    bus.retfie = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    do_reset();
    checks++; if (bus.intcon_q !== 8'h00) begin errors++; $display("FAIL reset_intcon got %h want %h", bus.intcon_q, 8'h00); end
    checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL reset_irq_take got %b want 0", bus.irq_take); end
    checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL reset_in_isr got %b want 0", bus.in_isr); end
    checks++; if (bus.irq_source !== 5'd0) begin errors++; $display("FAIL reset_irq_source got %0d want 0", bus.irq_source); end
    checks++; if (bus.wake !== 1'b0) begin errors++; $display("FAIL reset_wake got %b want 0", bus.wake); end
  endtask

  task automatic test_t0_accept;
    do_reset();
    write_intcon(8'hA0);
    bus.t0if_strobe = 1'b1; bus.instr_boundary = 1'b1;
    tick();
    bus.t0if_strobe = 1'b0;
    checks++; if (bus.intcon_q !== 8'hA4) begin errors++; $display("FAIL t0_flag got %h want %h", bus.intcon_q, 8'hA4); end
    checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL t0_early_take got %b want 0", bus.irq_take); end
    checks++; if (bus.wake !== 1'b1) begin errors++; $display("FAIL t0_wake got %b want 1", bus.wake); end
    tick();
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL t0_take got %b want 1", bus.irq_take); end
    checks++; if (bus.in_isr !== 1'b1) begin errors++; $display("FAIL t0_in_isr got %b want 1", bus.in_isr); end
    checks++; if (bus.intcon_q !== 8'h24) begin errors++; $display("FAIL t0_gie_clear got %h want %h", bus.intcon_q, 8'h24); end
    bus.instr_boundary = 1'b0;
    tick();
    checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL t0_take_pulse got %b want 0", bus.irq_take); end
    checks++; if (bus.in_isr !== 1'b1) begin errors++; $display("FAIL t0_in_isr_hold got %b want 1", bus.in_isr); end
    finish_isr();
    checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL t0_retfie_idle got %b want 0", bus.in_isr); end
    checks++; if (bus.intcon_q !== 8'hA4) begin errors++; $display("FAIL t0_retfie_gie got %h want %h", bus.intcon_q, 8'hA4); end
  endtask

  task automatic test_peie_gate;
    do_reset();
    bus.pir_q = 16'h0001; bus.pie_q = 16'h0001;
    write_intcon(8'h80);
    bus.instr_boundary = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL peie_off_take got %b want 0", bus.irq_take); end
      checks++; if (bus.wake !== 1'b0) begin errors++; $display("FAIL peie_off_wake got %b want 0", bus.wake); end
    end
    write_intcon(8'hC0);
    checks++; if (bus.wake !== 1'b1) begin errors++; $display("FAIL peie_on_wake got %b want 1", bus.wake); end
    checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL peie_write_take got %b want 0", bus.irq_take); end
    tick();
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL peie_on_take got %b want 1", bus.irq_take); end
    checks++; if (bus.intcon_q !== 8'h40) begin errors++; $display("FAIL peie_intcon got %h want %h", bus.intcon_q, 8'h40); end
    bus.pir_q = 16'h0000;
    finish_isr();
  endtask

  task automatic test_gie_off;
    do_reset();
    write_intcon(8'h10);
    bus.intf_strobe = 1'b1; bus.instr_boundary = 1'b1;
    tick();
    bus.intf_strobe = 1'b0;
    checks++; if (bus.wake !== 1'b1) begin errors++; $display("FAIL gie_off_wake got %b want 1", bus.wake); end
    checks++; if (bus.intcon_q !== 8'h12) begin errors++; $display("FAIL gie_off_intcon got %h want %h", bus.intcon_q, 8'h12); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL gie_off_take got %b want 0", bus.irq_take); end
      checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL gie_off_in_isr got %b want 0", bus.in_isr); end
    end
  endtask

  task automatic test_wait_ack;
    do_reset();
    write_intcon(8'h90);
    bus.intf_strobe = 1'b1;
    tick();
    bus.intf_strobe = 1'b0; bus.instr_boundary = 1'b1;
    tick();
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL wack_take got %b want 1", bus.irq_take); end
    checks++; if (bus.intcon_q !== 8'h12) begin errors++; $display("FAIL wack_intcon got %h want %h", bus.intcon_q, 8'h12); end
    write_intcon(8'h92);
    checks++; if (bus.intcon_q !== 8'h92) begin errors++; $display("FAIL wack_gie_reenable got %h want %h", bus.intcon_q, 8'h92); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.in_isr !== 1'b1) begin errors++; $display("FAIL wack_in_isr got %b want 1", bus.in_isr); end
      checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL wack_no_nest got %b want 0", bus.irq_take); end
    end
    bus.instr_boundary = 1'b0; bus.vector_ack = 1'b1;
    tick();
    bus.vector_ack = 1'b0;
    checks++; if (bus.in_isr !== 1'b1) begin errors++; $display("FAIL wack_after_ack got %b want 1", bus.in_isr); end
    bus.retfie = 1'b1;
    tick();
    bus.retfie = 1'b0;
    checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL wack_retfie got %b want 0", bus.in_isr); end
    checks++; if (bus.intcon_q !== 8'h92) begin errors++; $display("FAIL wack_retfie_gie got %h want %h", bus.intcon_q, 8'h92); end
    tick();
    checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL wack_no_boundary got %b want 0", bus.irq_take); end
    bus.instr_boundary = 1'b1;
    tick();
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL wack_reaccept got %b want 1", bus.irq_take); end
  endtask

  task automatic test_write_vs_strobe;
    do_reset();
    bus.intcon_wr_en = 1'b1; bus.intcon_d = 8'h00; bus.rbif_strobe = 1'b1;
    tick();
    bus.intcon_wr_en = 1'b0; bus.rbif_strobe = 1'b0;
    checks++; if (bus.intcon_q !== 8'h01) begin errors++; $display("FAIL strobe_beats_write got %h want %h", bus.intcon_q, 8'h01); end
    write_intcon(8'h08);
    checks++; if (bus.intcon_q !== 8'h08) begin errors++; $display("FAIL write_clears_flag got %h want %h", bus.intcon_q, 8'h08); end
  endtask

  task automatic test_accept_beats_write;
    do_reset();
    write_intcon(8'h88);
    bus.rbif_strobe = 1'b1;
    tick();
    bus.rbif_strobe = 1'b0;
    checks++; if (bus.intcon_q !== 8'h89) begin errors++; $display("FAIL abw_setup got %h want %h", bus.intcon_q, 8'h89); end
    bus.instr_boundary = 1'b1; bus.intcon_wr_en = 1'b1; bus.intcon_d = 8'h80;
    tick();
    bus.intcon_wr_en = 1'b0; bus.instr_boundary = 1'b0;
    checks++; if (bus.intcon_q !== 8'h00) begin errors++; $display("FAIL abw_gie got %h want %h", bus.intcon_q, 8'h00); end
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL abw_take got %b want 1", bus.irq_take); end
    finish_isr();
    checks++; if (bus.intcon_q !== 8'h80) begin errors++; $display("FAIL abw_retfie got %h want %h", bus.intcon_q, 8'h80); end
  endtask

  task automatic test_retfie_idle;
    do_reset();
    bus.retfie = 1'b1; bus.vector_ack = 1'b1;
    tick();
    bus.retfie = 1'b0; bus.vector_ack = 1'b0;
    checks++; if (bus.intcon_q !== 8'h80) begin errors++; $display("FAIL idle_retfie_gie got %h want %h", bus.intcon_q, 8'h80); end
    checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL idle_retfie_state got %b want 0", bus.in_isr); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    write_intcon(8'h90);
    bus.intf_strobe = 1'b1;
    tick();
    bus.intf_strobe = 1'b0; bus.instr_boundary = 1'b1;
    tick();
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL rstmid_take got %b want 1", bus.irq_take); end
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.instr_boundary = 1'b0;
    checks++; if (bus.irq_take !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %b want 0", bus.irq_take); end
    checks++; if (bus.in_isr !== 1'b0) begin errors++; $display("FAIL rstmid_in_isr got %b want 0", bus.in_isr); end
    checks++; if (bus.intcon_q !== 8'h00) begin errors++; $display("FAIL rstmid_intcon got %h want %h", bus.intcon_q, 8'h00); end
  endtask

  task automatic test_source_id;
    logic [4:0] want;
    do_reset();
    bus.pir_q = 16'h0800; bus.pie_q = 16'h0800;
    write_intcon(8'hD0);
    bus.intf_strobe = 1'b1;
    tick();
    bus.intf_strobe = 1'b0; bus.instr_boundary = 1'b1;
    tick();
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL src_both_take got %b want 1", bus.irq_take); end
    checks++; if (bus.irq_source !== 5'd0) begin errors++; $display("FAIL src_both got %0d want 0", bus.irq_source); end
    finish_isr();
    write_intcon(8'hC0);
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    want = SRC_ON ? 5'd14 : 5'd0;
    checks++; if (bus.irq_take !== 1'b1) begin errors++; $display("FAIL src_pir_take got %b want 1", bus.irq_take); end
    checks++; if (bus.irq_source !== want) begin errors++; $display("FAIL src_pir2_3 got %0d want %0d", bus.irq_source, want); end
    tick();
    checks++; if (bus.irq_source !== want) begin errors++; $display("FAIL src_hold got %0d want %0d", bus.irq_source, want); end
  endtask

  task automatic test_random;
    bit [7:0]  m_intcon, ni;
    bit        m_active, m_take, m_acked, acc, pend;
    bit [4:0]  m_src;
    bit [15:0] pir, pie;
    do_reset();
    m_intcon = 8'h00; m_active = 1'b0; m_take = 1'b0; m_acked = 1'b0; m_src = 5'd0;
    pir = 16'h0; pie = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      rst                = ($urandom_range(0, 149) == 0);
      bus.intcon_wr_en   = ($urandom_range(0, 7) == 0);
      bus.intcon_d       = 8'($urandom);
      bus.t0if_strobe    = ($urandom_range(0, 5) == 0);
      bus.intf_strobe    = ($urandom_range(0, 5) == 0);
      bus.rbif_strobe    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        pir = 16'($urandom & $urandom & $urandom);
        pie = 16'($urandom | $urandom);
      end
      bus.pir_q          = pir;
      bus.pie_q          = pie;
      bus.instr_boundary = ($urandom_range(0, 1) == 0);
      bus.vector_ack     = ($urandom_range(0, 3) == 0);
      bus.retfie         = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      pend = model_pend(m_intcon, pir, pie);
      checks++; if (bus.intcon_q !== m_intcon) begin errors++; $display("FAIL rnd_intcon c=%0d got %h want %h", c, bus.intcon_q, m_intcon); end
      checks++; if (bus.irq_take !== m_take) begin errors++; $display("FAIL rnd_irq_take c=%0d got %b want %b", c, bus.irq_take, m_take); end
      checks++; if (bus.in_isr !== m_active) begin errors++; $display("FAIL rnd_in_isr c=%0d got %b want %b", c, bus.in_isr, m_active); end
      checks++; if (bus.wake !== pend) begin errors++; $display("FAIL rnd_wake c=%0d got %b want %b", c, bus.wake, pend); end
      checks++; if (bus.irq_source !== m_src) begin errors++; $display("FAIL rnd_irq_source c=%0d got %0d want %0d", c, bus.irq_source, m_src); end
      if (rst) begin
        m_intcon = 8'h00; m_active = 1'b0; m_take = 1'b0; m_acked = 1'b0; m_src = 5'd0;
      end else begin
        acc = !m_active && m_intcon[7] && pend && bus.instr_boundary;
        ni = bus.intcon_wr_en ? bus.intcon_d : m_intcon;
        if (bus.t0if_strobe) ni[2] = 1'b1;
        if (bus.intf_strobe) ni[1] = 1'b1;
        if (bus.rbif_strobe) ni[0] = 1'b1;
        if (bus.retfie)      ni[7] = 1'b1;
        if (acc)             ni[7] = 1'b0;
        if (acc) begin
          if (SRC_ON) m_src = model_lowest(m_intcon, pir, pie);
          m_active = 1'b1; m_acked = 1'b0; m_take = 1'b1;
        end else begin
          // Ack only counts once the take cycle is over; RETFIE only ends a handler that was vectored.
          if (m_active && m_acked && bus.retfie) m_active = 1'b0;
          else if (m_active && !m_take && !m_acked && bus.vector_ack) m_acked = 1'b1;
          m_take = 1'b0;
        end
        m_intcon = ni;
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_t0_accept();
    test_peie_gate();
    test_gie_off();
    test_wait_ack();
    test_write_vs_strobe();
    test_accept_beats_write();
    test_retfie_idle();
    test_reset_mid();
    test_source_id();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
